sevenseg_mux_driver: RTL and testbench



---
 rtl/sevenseg_pkg.sv | 40 ++++
 rtl/sevenseg_hex_decode.sv | 37 +++
 rtl/sevenseg_mux_driver.sv | 213 +++++++++++++++++++++
 tb/tb_sevenseg_mux_driver.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/sevenseg_pkg.sv
// Shared definitions for the seven-segment display driver.
// Latency: none (constants, types and a helper function).
// Backpressure: not applicable.
//
// Contents: active-high abc_defg segment patterns for hex digits 0-F plus
// an all-off pattern, the scan FSM state type, and a clog2 helper that
// never returns less than 1 so single-entry indices still get a bit.
package sevenseg_pkg;

    // Bit order is {a, b, c, d, e, f, g}; 1 = segment lit (logical level).
    localparam logic [6:0] SEG_0   = 7'b1111110;
    localparam logic [6:0] SEG_1   = 7'b0110000;
    localparam logic [6:0] SEG_2   = 7'b1101101;
    localparam logic [6:0] SEG_3   = 7'b1111001;
    localparam logic [6:0] SEG_4   = 7'b0110011;
    localparam logic [6:0] SEG_5   = 7'b1011011;
    localparam logic [6:0] SEG_6   = 7'b1011111;
    localparam logic [6:0] SEG_7   = 7'b1110000;
    localparam logic [6:0] SEG_8   = 7'b1111111;
    localparam logic [6:0] SEG_9   = 7'b1111011;
    localparam logic [6:0] SEG_A   = 7'b1110111;
    localparam logic [6:0] SEG_B   = 7'b0011111;
    localparam logic [6:0] SEG_C   = 7'b1001110;
    localparam logic [6:0] SEG_D   = 7'b0111101;
    localparam logic [6:0] SEG_E   = 7'b1001111;
    localparam logic [6:0] SEG_F   = 7'b1000111;
    localparam logic [6:0] SEG_OFF = 7'b0000000;

    // SHOW: one digit lit. GAP: everything dark between digits.
    typedef enum logic {
        SHOW = 1'b0,
        GAP  = 1'b1
    } scan_state_t;

    // Width needed to count/index n items, with a floor of 1 bit.
    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/sevenseg_hex_decode.sv
// Hex nibble to seven-segment pattern decoder (logical, active-high).
// Latency: purely combinational, zero cycles.
// Backpressure: none; output follows input continuously.
//
// Ports:
//   nib_i  [3:0]  hex value 0-F
//   seg_o  [6:0]  abc_defg pattern, seg_o[6]=a ... seg_o[0]=g
module sevenseg_hex_decode
    import sevenseg_pkg::*;
(
    input  logic [3:0] nib_i,
    output logic [6:0] seg_o
);

    always_comb begin
        seg_o = SEG_OFF;
        case (nib_i)
            4'h0: seg_o = SEG_0;
            4'h1: seg_o = SEG_1;
            4'h2: seg_o = SEG_2;
            4'h3: seg_o = SEG_3;
            4'h4: seg_o = SEG_4;
            4'h5: seg_o = SEG_5;
            4'h6: seg_o = SEG_6;
            4'h7: seg_o = SEG_7;
            4'h8: seg_o = SEG_8;
            4'h9: seg_o = SEG_9;
            4'hA: seg_o = SEG_A;
            4'hB: seg_o = SEG_B;
            4'hC: seg_o = SEG_C;
            4'hD: seg_o = SEG_D;
            4'hE: seg_o = SEG_E;
            4'hF: seg_o = SEG_F;
        endcase
    end

endmodule

// File: rtl/sevenseg_mux_driver.sv
// Time-multiplexed N-digit hex seven-segment driver with blanking gap.
// Latency: all pins registered; load/enable/state changes reach pins 1 cycle later.
// Backpressure: none; enable=0 darkens the display and freezes the scan position.
//
// Ports:
//   clk        system clock
//   rst        synchronous active-high reset
//   enable     1 = scan running, 0 = dark and frozen
//   load       capture data/dp_in into the shadow registers
//   data       hex nibbles, nibble i drives digit i (digit 0 = LS)
//   dp_in      decimal point per digit
//   segments   abc_defg, polarity per SEG_ACTIVE_LOW
//   dp         decimal point of the lit digit, polarity per SEG_ACTIVE_LOW
//   anodes     one-hot digit select, polarity per AN_ACTIVE_LOW
//   digit_idx  index of the digit the pins currently refer to
module sevenseg_mux_driver
    import sevenseg_pkg::*;
#(
    parameter int NUM_DIGITS     = 4,
    parameter int CLK_DIV        = 50000,
    parameter int BLANK_CYCLES   = 8,
    parameter int BLANK_LEADING  = 1,
    parameter int SEG_ACTIVE_LOW = 0,
    parameter int AN_ACTIVE_LOW  = 1
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                enable,
    input  logic                                load,
    input  logic [4*NUM_DIGITS-1:0]             data,
    input  logic [NUM_DIGITS-1:0]               dp_in,
    output logic [6:0]                          segments,
    output logic                                dp,
    output logic [NUM_DIGITS-1:0]               anodes,
    output logic [clog2_min1(NUM_DIGITS)-1:0]   digit_idx
);

    localparam int IDX_W   = clog2_min1(NUM_DIGITS);
    localparam int PRESC_W = clog2_min1(CLK_DIV);
    localparam int GAP_W   = clog2_min1(BLANK_CYCLES);

    localparam logic [IDX_W-1:0]   LAST_IDX   = IDX_W'(NUM_DIGITS - 1);
    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(CLK_DIV - 1);
    // With no gap the GAP state is unreachable; the value only needs to be legal.
    localparam logic [GAP_W-1:0]   GAP_LAST   =
        GAP_W'((BLANK_CYCLES > 0) ? (BLANK_CYCLES - 1) : 0);

    // XOR masks applied at the output registers to get pin polarity.
    localparam logic [6:0]            SEG_XOR = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
    localparam logic                  DP_XOR  = (SEG_ACTIVE_LOW != 0);
    localparam logic [NUM_DIGITS-1:0] AN_XOR  = (AN_ACTIVE_LOW != 0) ? '1 : '0;

    // ------------------------------------------------------------------
    // Shadow registers
    // ------------------------------------------------------------------
    logic [4*NUM_DIGITS-1:0] shadow_dat_q, shadow_dat_d;
    logic [NUM_DIGITS-1:0]   shadow_dp_q,  shadow_dp_d;

    always_comb begin
        shadow_dat_d = load ? data  : shadow_dat_q;
        shadow_dp_d  = load ? dp_in : shadow_dp_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            shadow_dat_q <= '0;
            shadow_dp_q  <= '0;
        end else begin
            shadow_dat_q <= shadow_dat_d;
            shadow_dp_q  <= shadow_dp_d;
        end
    end

    // ------------------------------------------------------------------
    // Scan FSM: prescaler in SHOW, gap counter in GAP
    // ------------------------------------------------------------------
    scan_state_t          state_q, state_d;
    logic [PRESC_W-1:0]   presc_q, presc_d;
    logic [GAP_W-1:0]     gap_q,   gap_d;
    logic [IDX_W-1:0]     idx_q,   idx_d;
    logic [IDX_W-1:0]     idx_next;

    // With a single digit LAST_IDX is 0, so the wrap keeps the index at 0.
    assign idx_next = (idx_q == LAST_IDX) ? '0 : idx_q + IDX_W'(1);

    always_comb begin
        state_d = state_q;
        presc_d = presc_q;
        gap_d   = gap_q;
        idx_d   = idx_q;
        if (enable) begin
            case (state_q)
                SHOW: begin
                    if (presc_q == PRESC_LAST) begin
                        presc_d = '0;
                        if (BLANK_CYCLES == 0) begin
                            idx_d = idx_next;
                        end else begin
                            state_d = GAP;
                            gap_d   = '0;
                        end
                    end else begin
                        presc_d = presc_q + PRESC_W'(1);
                    end
                end
                GAP: begin
                    if (gap_q == GAP_LAST) begin
                        gap_d   = '0;
                        state_d = SHOW;
                        idx_d   = idx_next;
                    end else begin
                        gap_d = gap_q + GAP_W'(1);
                    end
                end
                default: state_d = SHOW;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= SHOW;
            presc_q <= '0;
            gap_q   <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            presc_q <= presc_d;
            gap_q   <= gap_d;
            idx_q   <= idx_d;
        end
    end

    // ------------------------------------------------------------------
    // Leading-zero blanking: digit i>0 blanks when it and every digit
    // above it hold 0. Digit 0 always shows so a zero value reads "0".
    // ------------------------------------------------------------------
    logic [NUM_DIGITS-1:0] lead_blank;

    always_comb begin
        logic upper_zero;
        lead_blank = '0;
        upper_zero = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            upper_zero    = upper_zero & (shadow_dat_q[i*4 +: 4] == 4'h0);
            lead_blank[i] = (BLANK_LEADING != 0) && upper_zero;
        end
    end

    // ------------------------------------------------------------------
    // Select the active digit's nibble, dp and blank flag
    // ------------------------------------------------------------------
    logic [3:0] nib_sel;
    logic       dp_sel;
    logic       blank_sel;

    always_comb begin
        nib_sel   = '0;
        dp_sel    = 1'b0;
        blank_sel = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx_q == IDX_W'(i)) begin
                nib_sel   = shadow_dat_q[i*4 +: 4];
                dp_sel    = shadow_dp_q[i];
                blank_sel = lead_blank[i];
            end
        end
    end

    logic [6:0] dec_seg;

    sevenseg_hex_decode u_hex_decode (
        .nib_i (nib_sel),
        .seg_o (dec_seg)
    );

    // ------------------------------------------------------------------
    // Output registers (logical levels computed, polarity applied here)
    // ------------------------------------------------------------------
    logic                  show;
    logic [6:0]            seg_d, seg_q;
    logic                  dp_d,  dp_q;
    logic [NUM_DIGITS-1:0] an_d,  an_q;
    logic [IDX_W-1:0]      idx_out_q;

    always_comb begin
        show  = enable && (state_q == SHOW);
        seg_d = ((show && !blank_sel) ? dec_seg : SEG_OFF) ^ SEG_XOR;
        // A blanked digit keeps its decimal point.
        dp_d  = (show && dp_sel) ^ DP_XOR;
        an_d  = (show ? (NUM_DIGITS'(1) << idx_q) : '0) ^ AN_XOR;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            seg_q     <= SEG_OFF ^ SEG_XOR;
            dp_q      <= DP_XOR;
            an_q      <= AN_XOR;
            idx_out_q <= '0;
        end else begin
            seg_q     <= seg_d;
            dp_q      <= dp_d;
            an_q      <= an_d;
            idx_out_q <= idx_q;
        end
    end

    assign segments  = seg_q;
    assign dp        = dp_q;
    assign anodes    = an_q;
    assign digit_idx = idx_out_q;

endmodule

// File: tb/tb_sevenseg_mux_driver.sv
// Directed bench for sevenseg_mux_driver with a per-cycle expected-pin queue.
// Two instances: leading blanking on (dut) and off (dut_nb), same stimulus.
module tb_sevenseg_mux_driver;

    localparam int N_DIG  = 4;
    localparam int CDIV   = 4;
    localparam int BLANK  = 2;
    localparam int PERIOD = CDIV + BLANK;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic        load;
    logic [15:0] data;
    logic [3:0]  dp_in;

    logic [6:0]  segments,  segments_nb;
    logic        dp,        dp_nb;
    logic [3:0]  anodes,    anodes_nb;
    logic [1:0]  digit_idx, digit_idx_nb;

    always #5 clk = ~clk;

    sevenseg_mux_driver #(
        .NUM_DIGITS(N_DIG), .CLK_DIV(CDIV), .BLANK_CYCLES(BLANK),
        .BLANK_LEADING(1), .SEG_ACTIVE_LOW(0), .AN_ACTIVE_LOW(1)
    ) dut (
        .clk(clk), .rst(rst), .enable(enable), .load(load),
        .data(data), .dp_in(dp_in),
        .segments(segments), .dp(dp), .anodes(anodes), .digit_idx(digit_idx)
    );

    sevenseg_mux_driver #(
        .NUM_DIGITS(N_DIG), .CLK_DIV(CDIV), .BLANK_CYCLES(BLANK),
        .BLANK_LEADING(0), .SEG_ACTIVE_LOW(0), .AN_ACTIVE_LOW(1)
    ) dut_nb (
        .clk(clk), .rst(rst), .enable(enable), .load(load),
        .data(data), .dp_in(dp_in),
        .segments(segments_nb), .dp(dp_nb), .anodes(anodes_nb), .digit_idx(digit_idx_nb)
    );

    // Reference segment table, indexed by hex value.
    logic [6:0] seg_tbl [16] = '{
        7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
        7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
        7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
        7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111
    };

    typedef struct packed {
        logic [3:0] an;
        logic [6:0] seg;
        logic [6:0] seg_nb;
        logic       dp;
        logic [1:0] idx;
    } exp_t;

    exp_t exp_q[$];

    // Reference model: position within a digit period plus current digit.
    logic [15:0] m_sh  = '0;
    logic [3:0]  m_dp  = '0;
    int          m_phase = 0;
    int          m_digit = 0;

    int tests = 0;
    int fails = 0;

    function automatic logic [6:0] exp_seg(input logic [15:0] sh, input int d, input bit bl);
        logic [15:0] hi;
        hi = sh >> (4 * d);
        if (bl && d > 0 && hi == 16'h0) return 7'b0000000;
        return seg_tbl[hi[3:0]];
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // One clock: predict pins from current model state and inputs, advance the
    // model, clock the DUT, then compare against the popped prediction.
    task automatic step();
        exp_t e;
        logic show;
        show     = !rst && enable && (m_phase < CDIV);
        e.idx    = rst ? 2'd0 : 2'(m_digit);
        e.an     = show ? ~(4'b0001 << m_digit) : 4'b1111;
        e.seg    = show ? exp_seg(m_sh, m_digit, 1'b1) : 7'b0000000;
        e.seg_nb = show ? exp_seg(m_sh, m_digit, 1'b0) : 7'b0000000;
        e.dp     = show ? m_dp[m_digit] : 1'b0;
        exp_q.push_back(e);

        if (rst) begin
            m_sh = '0; m_dp = '0; m_phase = 0; m_digit = 0;
        end else begin
            if (load) begin
                m_sh = data;
                m_dp = dp_in;
            end
            if (enable) begin
                m_phase++;
                if (m_phase == PERIOD) begin
                    m_phase = 0;
                    m_digit = (m_digit + 1) % N_DIG;
                end
            end
        end

        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        chk("anodes",    anodes,      e.an);
        chk("segments",  segments,    e.seg);
        chk("dp",        dp,          e.dp);
        chk("digit_idx", digit_idx,   e.idx);
        chk("nb_segs",   segments_nb, e.seg_nb);
        chk("nb_anodes", anodes_nb,   e.an);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic run_until(input int d, input int ph, input string tag);
        int n;
        n = 0;
        while (!(m_digit == d && m_phase == ph) && n < 100) begin
            step();
            n++;
        end
        if (n >= 100) begin
            fails++;
            $error("FAIL %s observed=timeout expected=digit %0d phase %0d", tag, d, ph);
        end
    endtask

    initial begin
        rst = 1'b1; enable = 1'b0; load = 1'b0; data = '0; dp_in = '0;

        // Reset held 3 cycles, then released with the scan disabled.
        run(3);
        rst = 1'b0;
        run(2);
        chk("rst_anodes", anodes, 4'b1111);
        chk("rst_segs",   segments, 7'b0000000);
        chk("rst_dp",     dp, 1'b0);

        // Load 12AF while disabled, then scan two full rotations.
        load = 1'b1; data = 16'h12AF; dp_in = 4'b0000;
        step();
        load = 1'b0; enable = 1'b1;
        step();
        chk("first_digit_seg", segments, 7'b1000111);
        chk("first_digit_an",  anodes,   4'b1110);
        run(2 * N_DIG * PERIOD);

        // Leading-zero blanking with a dp on the blanked top digit.
        load = 1'b1; data = 16'h0070; dp_in = 4'b1000;
        step();
        load = 1'b0;
        run(N_DIG * PERIOD + 2);

        // Load mid-SHOW of digit 0: pins change one cycle after the load edge.
        run_until(0, 1, "align_load");
        load = 1'b1; data = 16'h0005; dp_in = 4'b0000;
        step();
        chk("load_old_seg", segments, 7'b1111110);
        load = 1'b0;
        step();
        chk("load_new_seg", segments, 7'b1011011);
        run(PERIOD);

        // Drop enable mid-gap of digit 1, then resume.
        run_until(1, CDIV + 1, "align_gap");
        enable = 1'b0;
        run(10);
        chk("dis_anodes", anodes, 4'b1111);
        enable = 1'b1;
        step();
        chk("resume_gap_an", anodes, 4'b1111);
        step();
        chk("resume_d2_an",  anodes, 4'b1011);
        chk("resume_d2_idx", digit_idx, 2'd2);
        run(PERIOD);

        // Reset coincident with a load during SHOW of digit 2.
        run_until(2, 2, "align_rst");
        rst = 1'b1; load = 1'b1; data = 16'hFFFF; dp_in = 4'hF;
        step();
        chk("rst_mid_idx",  digit_idx, 2'd0);
        chk("rst_mid_an",   anodes,    4'b1111);
        chk("rst_mid_segs", segments,  7'b0000000);
        rst = 1'b0; load = 1'b0;
        step();
        chk("post_rst_seg", segments, 7'b1111110);
        chk("post_rst_an",  anodes,   4'b1110);
        chk("post_rst_dp",  dp,       1'b0);
        run(N_DIG * PERIOD);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
